mac_host_driver: RTL
====================

# mac_host_driver

Host-side driver for the iterative MAC's Tiny Tapeout pin interface. It accepts operand commands on a valid/ready port and drives the MAC's `ui_in`/`uio_in` pins. It waits for the iteration to complete, reads the accumulator back byte-by-byte through `uo_out`, and returns the assembled result on a valid/ready port. It sits on the host/FPGA side of the pin boundary and is the driving end of the same interface the testbench exercises.

## Interface
- `ACC_W`, 24: accumulator width in bits; a multiple of 8 in the range 8..32.
- `TIMEOUT`, 255: maximum number of cycles to wait for done. Used only when the timeout feature is compiled in.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: driver can accept a command.
- `cmd_a` in 8: operand A.
- `cmd_b` in 8: operand B.
- `cmd_clr` in 1: clear the accumulator before this MAC.
- `res_valid` out 1: result present.
- `res_ready` in 1: consumer accepts the result.
- `res_data` out ACC_W: accumulator value after the command.
- `res_err` out 1: result aborted by timeout. Always 0 when the timeout feature is compiled out.
- `pin_ui` out 8: drives MAC `ui_in`.
- `pin_uio` out 8: drives MAC `uio_in`.
  - [0] load A
  - [1] load B and start
  - [2] clear
  - [5:4] byte select
  - other bits 0
- `pin_uo` in 8: MAC `uo_out`, the selected accumulator byte.
- `pin_uio_out` in 8: MAC `uio_out`.
  - [7] busy
  - [6] done, a 1-cycle pulse

## Operation
- States: IDLE, LOAD_A, LOAD_B, WAIT, READ, HOLD.
- IDLE:
  - `cmd_ready`=1. All pins 0.
  - A handshake (`cmd_valid`&`cmd_ready`) latches a, b, clr and goes to LOAD_A.
- LOAD_A, 1 cycle:
  - `pin_ui`=a, `pin_uio[0]`=1, `pin_uio[2]`=latched clr.
  - Next state LOAD_B.
- LOAD_B, 1 cycle:
  - `pin_ui`=b, `pin_uio[1]`=1.
  - Next state WAIT. The timeout counter is cleared.
- WAIT:
  - Pins 0.
  - `pin_uio_out[6]`=1 goes to READ with byte index 0.
  - `busy` is ignored for control and only feeds the debug view.
- READ: NB = ACC_W/8 bytes, two cycles per byte.
  - Cycle 1: drive `pin_uio[5:4]`=index.
  - Cycle 2: sample `pin_uo` into `res_data[8*index +: 8]`.
  - After byte NB-1, go to HOLD.
- HOLD:
  - `res_valid`=1 and `res_data` is stable.
  - A `res_ready` handshake returns to IDLE.
  - `cmd_ready`=0 for the whole HOLD state; results are never dropped.
- Result bytes are little-endian: byte select 0 is bits [7:0].
- `res_data` is updated only in READ and is held from HOLD until the next READ.
- A done pulse arriving outside WAIT is ignored.
- A done pulse on the same cycle WAIT is entered is honoured.

## Timing
- Reset values:
  - `cmd_ready`=0 during reset, 1 the cycle after reset releases.
  - `res_valid`=0, `res_data`=0, `res_err`=0.
  - `pin_ui`=0, `pin_uio`=0.
  - State IDLE.
- Reset mid-operation: return to IDLE next cycle and discard partial results. `pin_uio` goes to 0 the same edge.
- Latency from command accept to `res_valid`: 2 + W + 2·NB + 1 cycles, where W is the number of cycles from WAIT entry to the done pulse, counting the done cycle.
- All outputs are registered. Pins change only on clock edges.
- Back-to-back: `res_ready` high in HOLD gives IDLE the next cycle. The next command can be accepted that cycle, so there is one idle cycle minimum between commands.

## Configuration
- `MAC_HOST_TIMEOUT_EN` defined:
  - WAIT counts cycles.
  - On reaching TIMEOUT without done, go to HOLD with `res_err`=1 and `res_data`=0. No READ happens.
  - `res_err` clears on the HOLD handshake.
- Undefined:
  - No counter. WAIT lasts indefinitely.
  - `res_err` is tied to 0.

## Test plan
- Reset for 3 cycles with `cmd_valid`=1 → no handshake. All outputs 0. `cmd_ready`=1 on the first cycle after release.
- Command a=3, b=5, clr=1; MAC model done after 8 cycles with acc=15 → pins show LOAD_A (0x03/0x05) then LOAD_B (0x05/0x02). Result 0x00000F with `res_err`=0.
- Follow-up command a=0xFF, b=0xFF, clr=0 → `res_data`=0x00FE10 (15+65025). The READ sequence drives `pin_uio[5:4]` = 0, 1, 2.
- `res_ready` held low for 20 cycles in HOLD, with `cmd_valid` high → `res_data` stable, `cmd_ready`=0, no new pin activity.
- Assert `rst` in the middle of READ (byte 1) → next cycle IDLE, `pin_uio`=0, `res_valid`=0. A fresh command completes correctly.
- With `MAC_HOST_TIMEOUT_EN` defined and TIMEOUT=16, MAC never signals done → after 16 WAIT cycles, `res_valid`=1, `res_err`=1, `res_data`=0. A late done pulse in IDLE is ignored.

Source files
------------

// File: rtl/mac_host_driver.sv
// mac_host_driver: host-side driver for the iterative MAC's Tiny Tapeout pins.
// Accepts an operand command, drives load/start pulses onto ui_in/uio_in,
// waits for the MAC's done pulse, reads the accumulator back one byte at a
// time through uo_out and presents the little-endian result on a
// valid/ready port.
//
// Optional feature: define MAC_HOST_TIMEOUT_EN to bound the wait for done to
// TIMEOUT cycles; an expired wait returns res_err=1 with res_data=0.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cmd_valid/cmd_ready           command handshake
//   cmd_a, cmd_b, cmd_clr         operands and clear-before-MAC flag
//   res_valid/res_ready           result handshake
//   res_data, res_err             assembled accumulator, timeout flag
//   pin_ui, pin_uio               drive MAC ui_in / uio_in
//   pin_uo, pin_uio_out           MAC uo_out (selected byte) / uio_out (busy, done)
module mac_host_driver #(
    parameter int unsigned ACC_W   = 24,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [7:0]       cmd_a,
    input  logic [7:0]       cmd_b,
    input  logic             cmd_clr,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_data,
    output logic             res_err,
    output logic [7:0]       pin_ui,
    output logic [7:0]       pin_uio,
    input  logic [7:0]       pin_uo,
    input  logic [7:0]       pin_uio_out
);

    localparam int unsigned NB    = ACC_W / 8;
    localparam int unsigned IDX_W = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_WAIT,
        S_READ,
        S_HOLD
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [7:0]         r_a, w_a_nxt;
    logic [7:0]         r_b, w_b_nxt;
    logic               r_clr, w_clr_nxt;
    logic [IDX_W-1:0]   r_idx, w_idx_nxt;
    logic               r_phase, w_phase_nxt;
    logic               r_cmd_ready, w_cmd_ready_nxt;
    logic               r_res_valid, w_res_valid_nxt;
    logic [ACC_W-1:0]   r_res_data, w_res_data_nxt;
    logic               r_res_err, w_res_err_nxt;
    logic [7:0]         r_pin_ui, w_pin_ui_nxt;
    logic [7:0]         r_pin_uio, w_pin_uio_nxt;
    logic               w_done;

`ifdef MAC_HOST_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
`endif

    assign w_done = pin_uio_out[6];

    // busy and the spare uio_out bits carry no control meaning here
    logic w_unused;
    assign w_unused = &{1'b0, pin_uio_out[7], pin_uio_out[5:0], (TIMEOUT != 0)};

    // next-state, datapath and registered-output values
    always_comb begin
        w_state_nxt    = r_state;
        w_a_nxt        = r_a;
        w_b_nxt        = r_b;
        w_clr_nxt      = r_clr;
        w_idx_nxt      = r_idx;
        w_phase_nxt    = r_phase;
        w_res_data_nxt = r_res_data;
        w_res_err_nxt  = r_res_err;
`ifdef MAC_HOST_TIMEOUT_EN
        w_cnt_nxt      = r_cnt;
`endif

        case (r_state)
            S_IDLE: begin
                if (cmd_valid && r_cmd_ready) begin
                    w_a_nxt     = cmd_a;
                    w_b_nxt     = cmd_b;
                    w_clr_nxt   = cmd_clr;
                    w_state_nxt = S_LOAD_A;
                end
            end
            S_LOAD_A: w_state_nxt = S_LOAD_B;
            S_LOAD_B: begin
                w_state_nxt = S_WAIT;
`ifdef MAC_HOST_TIMEOUT_EN
                w_cnt_nxt   = '0;
`endif
            end
            S_WAIT: begin
                if (w_done) begin
                    w_state_nxt = S_READ;
                    w_idx_nxt   = '0;
                    w_phase_nxt = 1'b0;
                end
`ifdef MAC_HOST_TIMEOUT_EN
                else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_state_nxt    = S_HOLD;
                    w_res_err_nxt  = 1'b1;
                    w_res_data_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
`endif
            end
            S_READ: begin
                // phase 0 presents the byte select, phase 1 captures uo_out
                if (!r_phase) begin
                    w_phase_nxt = 1'b1;
                end else begin
                    for (int unsigned i = 0; i < NB; i++) begin
                        if (r_idx == IDX_W'(i)) begin
                            w_res_data_nxt[8*i +: 8] = pin_uo;
                        end
                    end
                    w_phase_nxt = 1'b0;
                    if (r_idx == IDX_W'(NB - 1)) begin
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                    end
                end
            end
            S_HOLD: begin
                if (res_ready) begin
                    w_state_nxt   = S_IDLE;
                    w_res_err_nxt = 1'b0;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // outputs are registered, so they are decoded from the next state
        w_cmd_ready_nxt = (w_state_nxt == S_IDLE);
        w_res_valid_nxt = (w_state_nxt == S_HOLD);
        w_pin_ui_nxt    = 8'h00;
        w_pin_uio_nxt   = 8'h00;
        case (w_state_nxt)
            S_LOAD_A: begin
                w_pin_ui_nxt  = w_a_nxt;
                w_pin_uio_nxt = {5'b0, w_clr_nxt, 1'b0, 1'b1};
            end
            S_LOAD_B: begin
                w_pin_ui_nxt  = w_b_nxt;
                w_pin_uio_nxt = 8'h02;
            end
            S_READ:   w_pin_uio_nxt = {2'b00, w_idx_nxt, 4'b0000};
            default: ;
        endcase
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_clr       <= 1'b0;
            r_idx       <= '0;
            r_phase     <= 1'b0;
            r_cmd_ready <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_err   <= 1'b0;
            r_pin_ui    <= '0;
            r_pin_uio   <= '0;
`ifdef MAC_HOST_TIMEOUT_EN
            r_cnt       <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_a         <= w_a_nxt;
            r_b         <= w_b_nxt;
            r_clr       <= w_clr_nxt;
            r_idx       <= w_idx_nxt;
            r_phase     <= w_phase_nxt;
            r_cmd_ready <= w_cmd_ready_nxt;
            r_res_valid <= w_res_valid_nxt;
            r_res_data  <= w_res_data_nxt;
            r_res_err   <= w_res_err_nxt;
            r_pin_ui    <= w_pin_ui_nxt;
            r_pin_uio   <= w_pin_uio_nxt;
`ifdef MAC_HOST_TIMEOUT_EN
            r_cnt       <= w_cnt_nxt;
`endif
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_err   = r_res_err;
    assign pin_ui    = r_pin_ui;
    assign pin_uio   = r_pin_uio;

endmodule
